// File: rtl/cnn_pkg.sv
// Shared constants for the CNN engine: map geometry, data width, memory selects,
// flatten-stream FSM state codes and the most negative fixed-point value.
package cnn_pkg;

  localparam int MAP_W = 32;
  localparam int MAP_H = 32;
  localparam int DW    = 20;

  localparam logic [2:0] CSEL_NONE = 3'b000;
  localparam logic [2:0] CSEL_L0   = 3'b001;
  localparam logic [2:0] CSEL_L1   = 3'b011;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam logic [DW-1:0] DATA_MIN = 20'h80000;

endpackage

// File: rtl/cnn_skid_fifo.sv
// Two-entry synchronous FIFO; a push together with a pop is accepted even when
// full, since the popped slot is the one being refilled.
module cnn_skid_fifo #(
  parameter int W = 31
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty,
  output logic [1:0]   count
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   cnt;
  logic         do_push;
  logic         do_pop;

  assign do_pop  = pop && (cnt != 2'd0);
  assign do_push = push && ((cnt != 2'd2) || do_pop);
  assign dout    = mem[rd_ptr];
  assign full    = (cnt == 2'd2);
  assign empty   = (cnt == 2'd0);
  assign count   = cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/cnn_l1_flatten_stream.sv
// Reads the completed layer-1 pooled map in row-major order and streams it out
// with flat index and last marker, tracking the running signed maximum.
module cnn_l1_flatten_stream
  import cnn_pkg::*;
#(
  parameter int MAP_W = cnn_pkg::MAP_W,
  parameter int MAP_H = cnn_pkg::MAP_H,
  parameter int DW    = cnn_pkg::DW,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          crd,
  output logic [AW-1:0] caddr_rd,
  output logic [2:0]    csel,
  input  logic [DW-1:0] cdata_rd,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [AW-1:0] out_index,
  output logic          out_last,
  output logic [DW-1:0] max_data,
  output logic [AW-1:0] max_index
);

  localparam int            NPIX     = MAP_W * MAP_H;
  localparam logic [AW-1:0] LAST_IDX = AW'(NPIX - 1);
  localparam int            FW       = DW + AW + 1;

  logic [1:0]    state;
  logic [AW-1:0] wr_idx;
  logic          in_flight;
  logic          pop;
  logic          issue;
  logic [2:0]    demand;
  logic [FW-1:0] fifo_din;
  logic [FW-1:0] fifo_dout;
  logic          fifo_full;
  logic          fifo_empty;
  logic [1:0]    fifo_count;

  assign busy      = (state != ST_IDLE);
  assign csel      = busy ? CSEL_L1 : CSEL_NONE;
  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;

  // A read is only issued if its data is guaranteed a FIFO slot when it returns.
  assign demand = {1'b0, fifo_count} + {2'b00, in_flight} + {2'b00, !pop};
  assign issue  = (state == ST_READ) && (demand <= 3'd2) && !(fifo_full && !pop);
  assign crd    = issue;

  assign fifo_din = {(wr_idx == LAST_IDX), wr_idx, cdata_rd};
  assign {out_last, out_index, out_data} = fifo_dout;

  cnn_skid_fifo #(
    .W(FW)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (in_flight),
    .pop  (pop),
    .din  (fifo_din),
    .dout (fifo_dout),
    .full (fifo_full),
    .empty(fifo_empty),
    .count(fifo_count)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      done      <= 1'b0;
      caddr_rd  <= '0;
      wr_idx    <= '0;
      in_flight <= 1'b0;
      max_data  <= '0;
      max_index <= '0;
    end else begin
      done      <= 1'b0;
      in_flight <= issue;
      if (in_flight) begin
        wr_idx <= wr_idx + AW'(1);
      end
      if (pop && ($signed(out_data) > $signed(max_data))) begin
        max_data  <= out_data;
        max_index <= out_index;
      end
      case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_READ;
            caddr_rd  <= '0;
            wr_idx    <= '0;
            max_data  <= DATA_MIN;
            max_index <= '0;
          end
        end
        ST_READ: begin
          if (issue) begin
            caddr_rd <= caddr_rd + AW'(1);
            if (caddr_rd == LAST_IDX) begin
              state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (pop && out_last) begin
            state <= ST_IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
